// File: rtl/poly94_uart_pkg.sv
// Shared types and constants for the UART byte-path buffering.
`timescale 1ns/1ps
package poly94_uart_pkg;

  localparam int unsigned DATA_W            = 8;
  localparam int unsigned TX_DEPTH_LOG2_DEF = 4;
  localparam int unsigned RX_DEPTH_LOG2_DEF = 4;

  // Cycles spent in ACK waiting for the PHY to raise busy before giving up.
  localparam int unsigned ACK_TIMEOUT = 2;
  localparam int unsigned ACK_CNT_W   = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    ACK    = 2'd2,
    DRAIN  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word fall-through FIFO with extra-MSB full/empty pointers.
`timescale 1ns/1ps
module sync_fifo_fwft #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned PTR_W = DEPTH_LOG2 + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  // Flags, accepted operations and head read; a push while full is taken only alongside a pop.
  always_comb begin
    empty_o  = (wr_ptr_q == rd_ptr_q);
    full_o   = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
               (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
    do_pop   = pop_i && !empty_o;
    do_push  = push_i && (!full_o || do_pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    dout_o   = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
  end

  // Pointer and storage update.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (do_push) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= din_i;
    end
  end

endmodule

// File: rtl/uart_fifo_ctrl.sv
// UART byte-path buffering: TX/RX FIFOs, PHY launch sequencer, RX overrun flag.
`timescale 1ns/1ps
import poly94_uart_pkg::*;

module uart_fifo_ctrl #(
  parameter int unsigned TX_DEPTH_LOG2 = TX_DEPTH_LOG2_DEF,
  parameter int unsigned RX_DEPTH_LOG2 = RX_DEPTH_LOG2_DEF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] csr_tx_data_i,
  input  logic       csr_tx_wr_i,
  input  logic       csr_rx_rd_i,
  output logic [7:0] csr_rx_data_o,
  output logic       csr_tx_busy_o,
  output logic       csr_rx_not_empty_o,
  output logic [7:0] phy_tx_data_o,
  output logic       phy_tx_start_o,
  input  logic       phy_tx_busy_i,
  input  logic [7:0] phy_rx_data_i,
  input  logic       phy_rx_valid_i,
  output logic       rx_overrun_o,
  input  logic       overrun_clr_i
);

  tx_state_t            state_q;
  logic [ACK_CNT_W-1:0] ack_cnt_q;
  logic [7:0]           phy_tx_data_q;
  logic                 phy_tx_start_q;
  logic                 rx_overrun_q, rx_overrun_d;

  logic       tx_full, tx_empty, tx_push_c, tx_pop_c;
  logic [7:0] tx_head;
  logic       rx_full, rx_empty, overrun_set_c;

  sync_fifo_fwft #(.WIDTH(DATA_W), .DEPTH_LOG2(TX_DEPTH_LOG2)) u_tx_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (tx_push_c),
    .pop_i   (tx_pop_c),
    .din_i   (csr_tx_data_i),
    .dout_o  (tx_head),
    .full_o  (tx_full),
    .empty_o (tx_empty)
  );

  sync_fifo_fwft #(.WIDTH(DATA_W), .DEPTH_LOG2(RX_DEPTH_LOG2)) u_rx_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (phy_rx_valid_i),
    .pop_i   (csr_rx_rd_i),
    .din_i   (phy_rx_data_i),
    .dout_o  (csr_rx_data_o),
    .full_o  (rx_full),
    .empty_o (rx_empty)
  );

  // CPU writes while full are dropped; a byte leaves the TX FIFO only on an IDLE launch.
  always_comb begin
    tx_push_c     = csr_tx_wr_i && !tx_full;
    tx_pop_c      = (state_q == IDLE) && !tx_empty && !phy_tx_busy_i;
    overrun_set_c = phy_rx_valid_i && rx_full && !csr_rx_rd_i;
    rx_overrun_d  = overrun_set_c || (rx_overrun_q && !overrun_clr_i);
  end

  // Sticky overrun flag; a new drop wins over a coincident clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rx_overrun_q <= 1'b0;
    else       rx_overrun_q <= rx_overrun_d;
  end

  // TX launch sequencer: pop head, pulse start, wait for PHY busy to rise then fall.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      ack_cnt_q      <= '0;
      phy_tx_data_q  <= '0;
      phy_tx_start_q <= 1'b0;
    end else begin
      phy_tx_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (tx_pop_c) begin
            phy_tx_data_q  <= tx_head;
            phy_tx_start_q <= 1'b1;
            state_q        <= LAUNCH;
          end
        end
        LAUNCH: begin
          ack_cnt_q <= '0;
          state_q   <= ACK;
        end
        ACK: begin
          if (phy_tx_busy_i) begin
            state_q <= DRAIN;
          end else if (ack_cnt_q == ACK_CNT_W'(ACK_TIMEOUT - 1)) begin
            state_q <= IDLE;
          end else begin
            ack_cnt_q <= ack_cnt_q + ACK_CNT_W'(1);
          end
        end
        DRAIN: begin
          if (!phy_tx_busy_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign phy_tx_data_o      = phy_tx_data_q;
  assign phy_tx_start_o     = phy_tx_start_q;
  assign rx_overrun_o       = rx_overrun_q;
  assign csr_tx_busy_o      = tx_full;
  assign csr_rx_not_empty_o = !rx_empty;

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Self-checking bench for uart_fifo_ctrl: RX vector table plus TX sequences.
`timescale 1ns/1ps
module tb_uart_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] csr_tx_data = '0;
  logic       csr_tx_wr = 1'b0;
  logic       csr_rx_rd = 1'b0;
  logic [7:0] csr_rx_data;
  logic       csr_tx_busy;
  logic       csr_rx_not_empty;
  logic [7:0] phy_tx_data;
  logic       phy_tx_start;
  logic       phy_tx_busy;
  logic [7:0] phy_rx_data = '0;
  logic       phy_rx_valid = 1'b0;
  logic       rx_overrun;
  logic       overrun_clr = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  uart_fifo_ctrl dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .csr_tx_data_i      (csr_tx_data),
    .csr_tx_wr_i        (csr_tx_wr),
    .csr_rx_rd_i        (csr_rx_rd),
    .csr_rx_data_o      (csr_rx_data),
    .csr_tx_busy_o      (csr_tx_busy),
    .csr_rx_not_empty_o (csr_rx_not_empty),
    .phy_tx_data_o      (phy_tx_data),
    .phy_tx_start_o     (phy_tx_start),
    .phy_tx_busy_i      (phy_tx_busy),
    .phy_rx_data_i      (phy_rx_data),
    .phy_rx_valid_i     (phy_rx_valid),
    .rx_overrun_o       (rx_overrun),
    .overrun_clr_i      (overrun_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // PHY model: a frame lasts 10 cycles counted from the start cycle; busy is
  // raised the cycle after start and held for the remaining 9 cycles.
  logic [3:0] m_cnt = '0;
  bit         no_ack = 1'b0;
  bit         force_busy = 1'b0;
  always @(posedge clk) begin
    if (phy_tx_start && !no_ack) m_cnt <= 4'd9;
    else if (m_cnt != 0)         m_cnt <= m_cnt - 4'd1;
  end
  assign phy_tx_busy = force_busy | (m_cnt != 0);

  // Record every start pulse with its cycle and data.
  int         st_cyc[$];
  logic [7:0] st_dat[$];
  always @(negedge clk) begin
    if (phy_tx_start) begin
      st_cyc.push_back(cyc);
      st_dat.push_back(phy_tx_data);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tx_write(input logic [7:0] b);
    @(negedge clk);
    csr_tx_wr   = 1'b1;
    csr_tx_data = b;
    @(negedge clk);
    csr_tx_wr   = 1'b0;
  endtask

  task automatic wait_starts(input int n, input int budget);
    int k = 0;
    while (st_cyc.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (st_cyc.size() < n) begin
      errors++;
      $display("FAIL start_count: got %0d expected %0d within %0d cycles", st_cyc.size(), n, budget);
    end
  endtask

  task automatic chk_start(input string name, input int idx, input logic [7:0] exp);
    if (st_dat.size() > idx) chk(name, 32'(st_dat[idx]), 32'(exp));
    else chk({name, "_missing"}, 32'(st_dat.size()), 32'(idx + 1));
  endtask

  task automatic chk_gap(input string name, input int exp);
    if (st_cyc.size() >= 2) chk(name, 32'(st_cyc[1] - st_cyc[0]), 32'(exp));
    else chk({name, "_missing"}, 32'(st_cyc.size()), 32'd2);
  endtask

  typedef struct {
    bit         v;
    logic [7:0] d;
    bit         rd;
    bit         clr;
    bit         chk_d;
    logic [7:0] exp_d;
    bit         exp_ne;
    bit         exp_ov;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(bit v, logic [7:0] d, bit rd, bit clr, bit chk_d,
                              logic [7:0] exp_d, bit exp_ne, bit exp_ov);
    vec_t t;
    t.v = v; t.d = d; t.rd = rd; t.clr = clr; t.chk_d = chk_d;
    t.exp_d = exp_d; t.exp_ne = exp_ne; t.exp_ov = exp_ov;
    vecs.push_back(t);
  endfunction

  initial begin
    // Reset with RX strobes toggling: nothing may be captured.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      phy_rx_valid = (i % 2 == 0);
      phy_rx_data  = 8'h33;
    end
    chk("rst_tx_busy", 32'(csr_tx_busy), 32'd0);
    chk("rst_rx_ne", 32'(csr_rx_not_empty), 32'd0);
    chk("rst_start", 32'(phy_tx_start), 32'd0);
    chk("rst_tx_data", 32'(phy_tx_data), 32'd0);
    chk("rst_overrun", 32'(rx_overrun), 32'd0);
    chk("rst_rx_data", 32'(csr_rx_data), 32'd0);
    @(negedge clk);
    phy_rx_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_rx_ne", 32'(csr_rx_not_empty), 32'd0);

    // RX vector table.
    for (int i = 0; i < 16; i++) add(1, 8'(i), 0, 0, 0, 8'h00, 1, 0);
    add(1, 8'hAA, 0, 0, 0, 8'h00, 1, 1);
    for (int i = 0; i < 16; i++) add(0, 8'h00, 1, 0, 1, 8'(i), (i < 15), 1);
    add(0, 8'h00, 1, 0, 0, 8'h00, 0, 1);
    add(0, 8'h00, 0, 1, 0, 8'h00, 0, 0);
    add(1, 8'h55, 1, 0, 0, 8'h00, 1, 0);
    add(0, 8'h00, 1, 0, 1, 8'h55, 0, 0);
    for (int i = 0; i < 16; i++) add(1, 8'(8'h10 + i), 0, 0, 0, 8'h00, 1, 0);
    add(1, 8'h77, 1, 0, 1, 8'h10, 1, 0);
    add(1, 8'h88, 0, 1, 0, 8'h00, 1, 1);
    add(0, 8'h00, 0, 1, 0, 8'h00, 1, 0);
    for (int i = 0; i < 15; i++) add(0, 8'h00, 1, 0, 1, 8'(8'h11 + i), 1, 0);
    add(0, 8'h00, 1, 0, 1, 8'h77, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      phy_rx_valid = vecs[i].v;
      phy_rx_data  = vecs[i].d;
      csr_rx_rd    = vecs[i].rd;
      overrun_clr  = vecs[i].clr;
      #1;
      if (vecs[i].chk_d) chk($sformatf("rx_data[%0d]", i), 32'(csr_rx_data), 32'(vecs[i].exp_d));
      @(posedge clk);
      #1;
      chk($sformatf("rx_ne[%0d]", i), 32'(csr_rx_not_empty), 32'(vecs[i].exp_ne));
      chk($sformatf("rx_ov[%0d]", i), 32'(rx_overrun), 32'(vecs[i].exp_ov));
    end
    @(negedge clk);
    phy_rx_valid = 1'b0;
    csr_rx_rd    = 1'b0;
    overrun_clr  = 1'b0;

    // Two bytes through a well-behaved PHY.
    st_cyc.delete(); st_dat.delete();
    tx_write(8'h41);
    tx_write(8'h42);
    wait_starts(2, 60);
    chk_start("tx_first", 0, 8'h41);
    chk_start("tx_second", 1, 8'h42);
    chk_gap("tx_spacing", 12);
    repeat (20) @(negedge clk);

    // Fill with PHY stuck busy, overflow by one, then drain.
    st_cyc.delete(); st_dat.delete();
    force_busy = 1'b1;
    for (int i = 0; i < 17; i++) begin
      tx_write((i < 16) ? 8'(8'h60 + i) : 8'hEE);
      if (i == 14) chk("tx_busy_15", 32'(csr_tx_busy), 32'd0);
      if (i == 15) chk("tx_busy_16", 32'(csr_tx_busy), 32'd1);
      if (i == 16) chk("tx_busy_17", 32'(csr_tx_busy), 32'd1);
    end
    chk("stuck_no_start", 32'(st_cyc.size()), 32'd0);
    @(negedge clk);
    force_busy = 1'b0;
    wait_starts(16, 400);
    repeat (40) @(negedge clk);
    chk("drain_count", 32'(st_cyc.size()), 32'd16);
    for (int i = 0; i < 16; i++) chk_start($sformatf("drain[%0d]", i), i, 8'(8'h60 + i));
    chk("drain_tx_busy", 32'(csr_tx_busy), 32'd0);

    // PHY never acknowledges: sequencer must time out and carry on.
    st_cyc.delete(); st_dat.delete();
    no_ack = 1'b1;
    tx_write(8'h91);
    tx_write(8'h92);
    wait_starts(2, 50);
    chk_start("noack_first", 0, 8'h91);
    chk_start("noack_second", 1, 8'h92);
    chk_gap("noack_spacing", 4);
    tx_write(8'h93);
    wait_starts(3, 50);
    chk_start("noack_third", 2, 8'h93);
    no_ack = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
